// File: rtl/tree_input_packer.sv
// tree_input_packer: gathers a byte-serial sample stream into one NUM-lane
// parallel word for the multiplier tree. The word is presented as a one-cycle
// pulse on din_tvalid. Lanes with no sample hold PAD_VALUE, the tree's 1.0, so
// the tree product of a short frame is not changed by the empty lanes.
//
// Handshake: a sample is transferred on a clock edge where s_tvalid and s_tready
// are both high (a "beat"). s_tlast only has meaning on a beat. s_tready is
// registered. It rises on the first edge after reset release and then stays
// high, because the tree takes one word per cycle and never stalls this block.
// The downstream side has no ready signal. din_tvalid is a pulse that is only
// valid for that one cycle. din holds its last value between pulses and must
// be qualified with din_tvalid.
module tree_input_packer #(
  parameter int                    NUM        = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = 8'h80
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     s_tdata,
  input  logic                      s_tvalid,
  input  logic                      s_tlast,
  output logic                      s_tready,
  input  logic                      flush,
  output logic [NUM*DATA_WIDTH-1:0] din,
  output logic [NUM-1:0]            din_tvalid,
  output logic                      pkt_last,
  output logic                      pkt_short,
  output logic [15:0]               pkt_count
);

  localparam int CW = $clog2(NUM);
  localparam int W  = NUM * DATA_WIDTH;
  localparam logic [W-1:0]  PAD_WORD = {NUM{PAD_VALUE}};
  localparam logic [CW-1:0] LAST_LANE = CW'(NUM - 1);

  logic [CW-1:0] lane_cnt;
  logic [W-1:0]  coll_buf;
  logic [W-1:0]  next_buf;
  logic          beat;
  logic          fill_last;
  logic          emit;

  // Beat and emit decode. The packet is short unless this beat fills the top lane.
  always_comb begin
    beat      = s_tvalid & s_tready;
    fill_last = beat & (lane_cnt == LAST_LANE);
    emit      = fill_last | (beat & s_tlast) | (flush & ((lane_cnt != '0) | beat));
  end

  // Buffer contents including the current beat. An emit captures the word from here.
  always_comb begin
    next_buf = coll_buf;
    if (beat) begin
      next_buf[int'(lane_cnt)*DATA_WIDTH +: DATA_WIDTH] = s_tdata;
    end
  end

  // Ready register. It goes high on the first edge after reset and never drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_tready <= 1'b0;
    end else begin
      s_tready <= 1'b1;
    end
  end

  // Collect buffer and lane counter. Both go back to pad/zero on the edge that emits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_buf <= PAD_WORD;
      lane_cnt <= '0;
    end else if (emit) begin
      coll_buf <= PAD_WORD;
      lane_cnt <= '0;
    end else if (beat) begin
      coll_buf <= next_buf;
      lane_cnt <= lane_cnt + CW'(1);
    end
  end

  // Output word, one-cycle valid pulse, packet flags and the wrapping packet counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din        <= '0;
      din_tvalid <= '0;
      pkt_last   <= 1'b0;
      pkt_short  <= 1'b0;
      pkt_count  <= '0;
    end else if (emit) begin
      din        <= next_buf;
      din_tvalid <= '1;
      pkt_last   <= beat & s_tlast;
      pkt_short  <= ~fill_last;
      pkt_count  <= pkt_count + 16'd1;
    end else begin
      din_tvalid <= '0;
    end
  end

endmodule
